// File: rtl/rd_arbiter_if.sv
// Read-port bundle between icache, dcache, the arbiter and the AXI read bridge.
// master = the arbiter's view; slave = the caches/bridge side.
interface rd_arbiter_if;
    logic        inst_rd_req;
    logic [2:0]  inst_rd_type;
    logic [31:0] inst_rd_addr;
    logic        inst_rd_rdy;
    logic        inst_ret_valid;
    logic        inst_ret_last;
    logic [31:0] inst_ret_data;

    logic        data_rd_req;
    logic [2:0]  data_rd_type;
    logic [31:0] data_rd_addr;
    logic        data_rd_rdy;
    logic        data_ret_valid;
    logic        data_ret_last;
    logic [31:0] data_ret_data;

    logic        mem_rd_req;
    logic [2:0]  mem_rd_type;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_id;
    logic        mem_rd_rdy;
    logic        mem_ret_valid;
    logic        mem_ret_last;
    logic        mem_ret_id;
    logic [31:0] mem_ret_data;

    logic        inst_busy;
    logic        data_busy;

    modport master (
        input  inst_rd_req, inst_rd_type, inst_rd_addr,
        output inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        input  data_rd_req, data_rd_type, data_rd_addr,
        output data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        output mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_id,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_id, mem_ret_data,
        output inst_busy, data_busy
    );

    modport slave (
        output inst_rd_req, inst_rd_type, inst_rd_addr,
        input  inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        output data_rd_req, data_rd_type, data_rd_addr,
        input  data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        input  mem_rd_req, mem_rd_type, mem_rd_addr, mem_rd_id,
        output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_id, mem_ret_data,
        input  inst_busy, data_busy
    );
endinterface

// File: rtl/rd_arbiter.sv
// Purpose: arbitrates icache/dcache reads onto one bridge request register; optional inst aging via RD_ARB_AGING_EN.
// Latency: mem_rd_req one cycle after the source handshake; return path is combinational (zero cycles).
// Backpressure: request held stable in HOLD until mem_rd_rdy; no source is ready outside IDLE or while its read is outstanding.
module rd_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    rd_arbiter_if.master bus
);
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("rd_arbiter: MAX_WAIT must be in 1..15");
    end

    typedef enum logic {IDLE, HOLD} state_e;

    state_e      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic        id_q, id_d;
    logic        inst_busy_q, inst_busy_d;
    logic        data_busy_q, data_busy_d;

    logic        inst_elig, data_elig, force_inst;
    logic        grant_inst, grant_data;

    assign inst_elig = bus.inst_rd_req & ~inst_busy_q;
    assign data_elig = bus.data_rd_req & ~data_busy_q;

`ifdef RD_ARB_AGING_EN
    logic [3:0] wait_q, wait_d;

    assign force_inst = inst_elig & (wait_q == 4'(MAX_WAIT));

    // Count only the cycles where inst was eligible but lost to data.
    always_comb begin
        wait_d = wait_q;
        if (grant_inst) begin
            wait_d = '0;
        end else if (grant_data && inst_elig && (wait_q < 4'(MAX_WAIT))) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign force_inst = 1'b0;
`endif

    always_comb begin
        grant_data = (state_q == IDLE) & data_elig & ~force_inst;
        grant_inst = (state_q == IDLE) & inst_elig & ~grant_data;
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        id_d        = id_q;
        inst_busy_d = inst_busy_q;
        data_busy_d = data_busy_q;

        case (state_q)
            IDLE: begin
                if (grant_data || grant_inst) begin
                    state_d = HOLD;
                    id_d    = grant_data;
                    type_d  = grant_data ? bus.data_rd_type : bus.inst_rd_type;
                    addr_d  = grant_data ? bus.data_rd_addr : bus.inst_rd_addr;
                end
            end
            HOLD: begin
                if (bus.mem_rd_rdy) begin
                    state_d = IDLE;
                    if (id_q) begin
                        data_busy_d = 1'b1;
                    end else begin
                        inst_busy_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the set so a zero-latency bridge return on the accept edge leaves the source free.
        if (bus.mem_ret_valid && bus.mem_ret_last) begin
            if (bus.mem_ret_id) begin
                data_busy_d = 1'b0;
            end else begin
                inst_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            type_q      <= '0;
            addr_q      <= '0;
            id_q        <= 1'b0;
            inst_busy_q <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            inst_busy_q <= inst_busy_d;
            data_busy_q <= data_busy_d;
        end
    end

    assign bus.inst_rd_rdy    = grant_inst & reset;
    assign bus.data_rd_rdy    = grant_data & reset;

    assign bus.mem_rd_req     = (state_q == HOLD);
    assign bus.mem_rd_type    = type_q;
    assign bus.mem_rd_addr    = addr_q;
    assign bus.mem_rd_id      = id_q;

    assign bus.inst_busy      = inst_busy_q;
    assign bus.data_busy      = data_busy_q;

    assign bus.inst_ret_valid = bus.mem_ret_valid & ~bus.mem_ret_id;
    assign bus.inst_ret_last  = bus.mem_ret_last  & ~bus.mem_ret_id;
    assign bus.inst_ret_data  = bus.mem_ret_data;
    assign bus.data_ret_valid = bus.mem_ret_valid &  bus.mem_ret_id;
    assign bus.data_ret_last  = bus.mem_ret_last  &  bus.mem_ret_id;
    assign bus.data_ret_data  = bus.mem_ret_data;
endmodule

// File: tb/tb_rd_arbiter.sv
// Bench for rd_arbiter: directed scenarios plus random traffic, every cycle checked against a transaction-level model.
module tb_rd_arbiter;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rd_arbiter_if bus ();
    rd_arbiter #(.MAX_WAIT(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one optional held request, per-source busy flags, beats left per outstanding read.
    bit          h_vld;
    bit          h_id;
    logic [2:0]  h_type;
    logic [31:0] h_addr;
    bit          busy [2];
    int          rem  [2];
    int          wcnt;
    bit          bridge_on, stray_on;
    int          gap_pct;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int nbeats(logic [2:0] t);
        return (t == 3'b100) ? 8 : 1;
    endfunction

    function automatic logic [2:0] rnd_type();
        logic [2:0] t;
        t = 3'($urandom);
        if ($urandom_range(0, 1) == 1) t = 3'b100;
        return t;
    endfunction

    task automatic model_reset();
        h_vld = 0; busy[0] = 0; busy[1] = 0; rem[0] = 0; rem[1] = 0; wcnt = 0;
    endtask

    // Compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit ie, de, fi, wi, wd, clr_hit, acc;
        @(negedge clk);
        ie = bus.inst_rd_req && !busy[0];
        de = bus.data_rd_req && !busy[1];
        fi = 0;
`ifdef RD_ARB_AGING_EN
        fi = ie && (wcnt == MW);
`endif
        wd = reset && !h_vld && de && !fi;
        wi = reset && !h_vld && ie && !wd;
        chk("inst_rd_rdy", 32'(bus.inst_rd_rdy), 32'(wi));
        chk("data_rd_rdy", 32'(bus.data_rd_rdy), 32'(wd));
        chk("mem_rd_req", 32'(bus.mem_rd_req), 32'(h_vld));
        if (h_vld) begin
            chk("mem_rd_type", 32'(bus.mem_rd_type), 32'(h_type));
            chk("mem_rd_addr", bus.mem_rd_addr, h_addr);
            chk("mem_rd_id", 32'(bus.mem_rd_id), 32'(h_id));
        end else if (!reset) begin
            chk("rst_mem_rd_addr", bus.mem_rd_addr, 32'h0);
            chk("rst_mem_rd_type_id", {28'h0, bus.mem_rd_type, bus.mem_rd_id}, 32'h0);
        end
        chk("inst_busy", 32'(bus.inst_busy), 32'(busy[0]));
        chk("data_busy", 32'(bus.data_busy), 32'(busy[1]));
        chk("inst_ret_valid", 32'(bus.inst_ret_valid), 32'(bus.mem_ret_valid && !bus.mem_ret_id));
        chk("inst_ret_last", 32'(bus.inst_ret_last), 32'(bus.mem_ret_last && !bus.mem_ret_id));
        chk("data_ret_valid", 32'(bus.data_ret_valid), 32'(bus.mem_ret_valid && bus.mem_ret_id));
        chk("data_ret_last", 32'(bus.data_ret_last), 32'(bus.mem_ret_last && bus.mem_ret_id));
        if (bus.mem_ret_valid) begin
            chk("inst_ret_data", bus.inst_ret_data, bus.mem_ret_data);
            chk("data_ret_data", bus.data_ret_data, bus.mem_ret_data);
        end
        if (reset) begin
            clr_hit = bus.mem_ret_valid && bus.mem_ret_last;
            if (bus.mem_ret_valid && rem[bus.mem_ret_id] > 0) rem[bus.mem_ret_id]--;
            acc = h_vld && bus.mem_rd_rdy;
            if (acc) begin
                busy[h_id] = 1;
                rem[h_id]  = (clr_hit && bus.mem_ret_id == h_id) ? 0 : nbeats(h_type);
                h_vld      = 0;
            end
            if (clr_hit) busy[bus.mem_ret_id] = 0;
            if (wd || wi) begin
                if (wi) wcnt = 0;
                else if (ie && wcnt < MW) wcnt++;
                h_vld  = 1;
                h_id   = wd;
                h_type = wd ? bus.data_rd_type : bus.inst_rd_type;
                h_addr = wd ? bus.data_rd_addr : bus.inst_rd_addr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bridge();
        int pick;
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_id = 0;
        bus.mem_ret_data  = $urandom;
        if (!bridge_on) return;
        if (rem[0] == 0 && rem[1] == 0) begin
            if (stray_on && !h_vld && $urandom_range(0, 19) == 0) begin
                bus.mem_ret_valid = 1;
                bus.mem_ret_id    = 1'($urandom);
                bus.mem_ret_last  = 1'($urandom);
            end
            return;
        end
        if ($urandom_range(0, 99) < gap_pct) return;
        if (rem[0] > 0 && rem[1] > 0) pick = $urandom_range(0, 1);
        else pick = (rem[1] > 0) ? 1 : 0;
        bus.mem_ret_valid = 1;
        bus.mem_ret_id    = pick[0];
        bus.mem_ret_last  = (rem[pick] == 1);
    endtask

    task automatic drain();
        int k;
        bus.inst_rd_req = 0; bus.data_rd_req = 0; bus.mem_rd_rdy = 1;
        bridge_on = 1; gap_pct = 0;
        for (k = 0; k < 40; k++) begin
            if (!h_vld && !busy[0] && !busy[1] && rem[0] == 0 && rem[1] == 0) break;
            drive_bridge();
            step();
        end
        chk("drain_bound", 32'(k < 40), 32'd1);
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        bridge_on = 0;
    endtask

    task automatic instant_ret();
        bus.mem_ret_valid = h_vld && h_id && bus.mem_rd_rdy;
        bus.mem_ret_id    = 1;
        bus.mem_ret_last  = 1;
    endtask

    initial begin
        int arb, inst_arb, beats, got;
        bus.inst_rd_req = 0; bus.inst_rd_type = 0; bus.inst_rd_addr = 0;
        bus.data_rd_req = 0; bus.data_rd_type = 0; bus.data_rd_addr = 0;
        bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        bus.mem_ret_id = 0; bus.mem_ret_data = 0;
        bridge_on = 0; stray_on = 0; gap_pct = 0;
        model_reset();
        reset = 0;

        // Reset state, with both sources requesting.
        bus.inst_rd_req = 1; bus.data_rd_req = 1;
        #2;
        chk("rst_rdy", {30'h0, bus.inst_rd_rdy, bus.data_rd_rdy}, 32'h0);
        chk("rst_memreq", 32'(bus.mem_rd_req), 32'h0);
        step(); step();
        bus.inst_rd_req = 0; bus.data_rd_req = 0;
        reset = 1;

        // Single inst line read.
        bus.inst_rd_req = 1; bus.inst_rd_type = 3'b100; bus.inst_rd_addr = 32'h1C00_0000;
        bus.mem_rd_rdy = 1;
        #1 chk("line_inst_rdy", 32'(bus.inst_rd_rdy), 32'd1);
        step();
        bus.inst_rd_req = 0;
        chk("line_memreq", 32'(bus.mem_rd_req), 32'd1);
        chk("line_addr", bus.mem_rd_addr, 32'h1C00_0000);
        chk("line_type", 32'(bus.mem_rd_type), 32'd4);
        chk("line_id", 32'(bus.mem_rd_id), 32'd0);
        step();
        chk("line_busy_set", 32'(bus.inst_busy), 32'd1);
        bridge_on = 1; gap_pct = 0; beats = 0;
        for (int k = 1; k <= 20; k++) begin
            drive_bridge();
            step();
            if (!bus.inst_busy) begin beats = k; break; end
        end
        chk("line_beats_to_idle", 32'(beats), 32'd8);
        drain();

        // Simultaneous requests: data first, inst once data is busy.
        bus.inst_rd_req = 1; bus.inst_rd_type = 0; bus.inst_rd_addr = 32'h0000_1000;
        bus.data_rd_req = 1; bus.data_rd_type = 0; bus.data_rd_addr = 32'h0000_2000;
        bus.mem_rd_rdy = 0;
        #1 chk("sim_rdys", {30'h0, bus.inst_rd_rdy, bus.data_rd_rdy}, 32'h1);
        step();
        chk("sim_id", 32'(bus.mem_rd_id), 32'd1);
        bus.mem_rd_rdy = 1;
        step();
        chk("sim_inst_next", 32'(bus.inst_rd_rdy), 32'd1);
        step();
        drain();

        // Backpressure for 5 cycles.
        bus.data_rd_req = 1; bus.data_rd_type = 3'b100; bus.data_rd_addr = 32'hA5A5_0040;
        bus.mem_rd_rdy = 0;
        step();
        bus.inst_rd_req = 1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_addr", bus.mem_rd_addr, 32'hA5A5_0040);
            chk("bp_type_id", {28'h0, bus.mem_rd_type, bus.mem_rd_id}, 32'h9);
            chk("bp_no_rdy", {30'h0, bus.inst_rd_rdy, bus.data_rd_rdy}, 32'h0);
            step();
        end
        bus.mem_rd_rdy = 1;
        step();
        chk("bp_accepted", 32'(bus.mem_rd_req), 32'd0);
        drain();

        // Aging (or strict priority without it): data saturates, returns instantly.
        bus.inst_rd_req = 1; bus.inst_rd_type = 0; bus.inst_rd_addr = 32'h0000_3000;
        bus.data_rd_req = 1; bus.data_rd_type = 0; bus.data_rd_addr = 32'h0000_4000;
        bus.mem_rd_rdy = 1;
        arb = 0; inst_arb = 0;
        for (int k = 0; k < 40 && inst_arb == 0 && arb < 8; k++) begin
            instant_ret();
            #1;
            if (bus.data_rd_rdy || bus.inst_rd_rdy) begin
                arb++;
                if (bus.inst_rd_rdy) inst_arb = arb;
            end
            step();
        end
`ifdef RD_ARB_AGING_EN
        chk("aging_inst_arb", 32'(inst_arb), 32'd4);
`else
        chk("strict_inst_starved", 32'(inst_arb), 32'd0);
        bus.data_rd_req = 0;
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            instant_ret();
            #1;
            if (bus.inst_rd_rdy) got = 1;
            step();
        end
        chk("strict_inst_after_drop", 32'(got), 32'd1);
`endif
        drain();

        // Interleaved returns during an inst line.
        bus.inst_rd_req = 1; bus.inst_rd_type = 3'b100; bus.inst_rd_addr = 32'h0000_5000;
        bus.mem_rd_rdy = 1;
        step();
        bus.inst_rd_req = 0;
        step();
        bus.data_rd_req = 1; bus.data_rd_type = 0; bus.data_rd_addr = 32'h0000_6000;
        step();
        bus.data_rd_req = 0;
        step();
        bus.mem_ret_valid = 1; bus.mem_ret_id = 0; bus.mem_ret_last = 0; bus.mem_ret_data = 32'h1111_0000;
        step();
        bus.mem_ret_valid = 1; bus.mem_ret_id = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'h2222_0000;
        #1 chk("ilv_route", {28'h0, bus.inst_ret_valid, bus.inst_ret_last, bus.data_ret_valid, bus.data_ret_last}, 32'h3);
        step();
        chk("ilv_busy", {30'h0, bus.inst_busy, bus.data_busy}, 32'h2);
        drain();

        // Asynchronous reset during HOLD with a data read outstanding.
        bus.data_rd_req = 1; bus.data_rd_type = 0; bus.data_rd_addr = 32'h0000_7000;
        bus.mem_rd_rdy = 1;
        step();
        bus.data_rd_req = 0;
        step();
        bus.inst_rd_req = 1; bus.inst_rd_type = 3'b100; bus.inst_rd_addr = 32'h0000_8000;
        bus.mem_rd_rdy = 0;
        step();
        chk("arst_pre_hold", 32'(bus.mem_rd_req), 32'd1);
        #2 reset = 0;
        #1;
        chk("arst_memreq", 32'(bus.mem_rd_req), 32'd0);
        chk("arst_busy", {30'h0, bus.inst_busy, bus.data_busy}, 32'h0);
        chk("arst_addr", bus.mem_rd_addr, 32'h0);
        chk("arst_rdy", 32'(bus.inst_rd_rdy), 32'd0);
        model_reset();
        step();
        reset = 1;
        bus.inst_rd_req = 0;
        bus.data_rd_req = 1; bus.data_rd_addr = 32'h0000_9000; bus.mem_rd_rdy = 1;
        #1 chk("post_rst_first_arb", 32'(bus.data_rd_rdy), 32'd1);
        step();
        chk("post_rst_memreq", 32'(bus.mem_rd_req), 32'd1);
        drain();

        // Random traffic.
        bridge_on = 1; stray_on = 1; gap_pct = 30;
        for (int k = 0; k < 3000; k++) begin
            bus.inst_rd_req  = ($urandom_range(0, 2) != 0);
            bus.inst_rd_type = rnd_type();
            bus.inst_rd_addr = $urandom;
            bus.data_rd_req  = ($urandom_range(0, 2) != 0);
            bus.data_rd_type = rnd_type();
            bus.data_rd_addr = $urandom;
            bus.mem_rd_rdy   = ($urandom_range(0, 2) != 0);
            drive_bridge();
            step();
        end
        stray_on = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rd_arbiter.md
RD_ARBITER -- requirements
Module: rd_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: number of lost arbitration cycles before inst is forced to win; legal range 1..15.
REQ-002 clk  in  1  the only clock; every register updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-004 inst_rd_req / inst_rd_type / inst_rd_addr  in  1/3/32  icache read request, with type 3'b100 meaning a cache line.
REQ-005 inst_rd_rdy  out  1  inst request accepted this cycle when inst_rd_req=1.
REQ-006 inst_ret_valid / inst_ret_last / inst_ret_data  out  1/1/32  inst read return beats.
REQ-007 data_rd_req / data_rd_type / data_rd_addr  in  1/3/32  dcache read request, same encoding as inst.
REQ-008 data_rd_rdy  out  1  data request accepted this cycle.
REQ-009 data_ret_valid / data_ret_last / data_ret_data  out  1/1/32  data read return beats.
REQ-010 mem_rd_req / mem_rd_type / mem_rd_addr / mem_rd_id  out  1/3/32/1  request to the AXI bridge; id 0 = inst, 1 = data.
REQ-011 mem_rd_rdy  in  1  the bridge accepts the request this cycle.
REQ-012 mem_ret_valid / mem_ret_last / mem_ret_id / mem_ret_data  in  1/1/1/32  bridge return beats.
REQ-013 inst_busy / data_busy  out  1/1  the source has a read outstanding.

Function
REQ-014 The FSM SHALL have two states: IDLE, with the request register empty, and HOLD, with mem_rd_req=1.
REQ-015 A source is eligible when its req=1 and its busy flag is 0.
REQ-016 In IDLE, arbitration is combinational: data wins if eligible; otherwise inst wins if eligible.
REQ-017 Only the winner's *_rd_rdy SHALL be 1, and only in IDLE.
REQ-018 On a winner handshake, type, addr and id are latched and the FSM goes to HOLD, so mem_rd_req rises exactly one cycle after the source handshake.
REQ-019 In HOLD, mem_rd_* SHALL stay stable until mem_rd_rdy=1.
REQ-020 When mem_rd_rdy=1 in HOLD, the FSM returns to IDLE and the busy flag of the latched id is set in the same edge.
REQ-021 A new arbitration SHALL NOT happen in the cycle of mem_rd_rdy: HOLD→IDLE→HOLD costs at least 2 cycles per request.
REQ-022 A busy flag clears on mem_ret_valid & mem_ret_last with a matching mem_ret_id, for both single beats and 8-beat lines.
REQ-023 Busy set for one id and clear for the other id in the same edge SHALL both take effect.
REQ-024 inst_ret_valid = mem_ret_valid & !mem_ret_id, and inst_ret_last likewise.
REQ-025 data_ret_valid = mem_ret_valid & mem_ret_id, and data_ret_last likewise.
REQ-026 Both *_ret_data outputs = mem_ret_data; the return path is purely combinational with zero latency.
REQ-027 A return beat whose id has busy=0 SHALL still be forwarded; the busy flag is unchanged.
REQ-028 The block has no request queue: at most one request sits in the register and at most one read is outstanding per source.

Reset
REQ-029 While reset=0, the following SHALL be forced immediately, independent of clk: FSM=IDLE, mem_rd_req=0, mem_rd_type=0, mem_rd_addr=0, mem_rd_id=0, inst_busy=0, data_busy=0, wait counter=0.
REQ-030 While reset=0, *_rd_rdy=0.
REQ-031 A reset asserted while in HOLD or with a read outstanding abandons that transaction; no retry is made after release.
REQ-032 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro RD_ARB_AGING_EN defined: a 4-bit wait counter increments, saturating at MAX_WAIT, in each IDLE cycle where inst is eligible but data wins.
REQ-034 With RD_ARB_AGING_EN, when wait counter == MAX_WAIT and inst is eligible, inst wins regardless of data; the counter clears on any inst handshake.
REQ-035 Macro RD_ARB_AGING_EN undefined: there is no counter and data has strict priority (REQ-016 only).

Verification
REQ-036 Single inst line read: inst req type 4 addr 0x1C000000, mem_rd_rdy=1 → mem_rd_req high 1 cycle after inst_rd_rdy; inst_busy=1 until the 8th beat (last), then 0.
REQ-037 Simultaneous req: inst and data both request in IDLE → data_rd_rdy=1 and inst_rd_rdy=0; mem_rd_id=1; inst wins in the next IDLE cycle once its busy flag is 0.
REQ-038 Backpressure: mem_rd_rdy held 0 for 5 cycles → mem_rd_addr/type/id constant, no *_rd_rdy asserted; accepted on cycle 6.
REQ-039 Aging (EN, MAX_WAIT=3): data requests back-to-back with instant returns, inst requesting → inst granted on the 4th arbitration; without the macro, inst waits until data_rd_req drops.
REQ-040 Interleaved returns: data single-beat return (id 1, last) during inst line burst → data_busy clears, inst_busy stays 1, each beat routed only to its own port.
REQ-041 Reset mid-HOLD: reset=0 asynchronously during HOLD → mem_rd_req=0 before the next clk edge; busy flags=0.
